nn_mac_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one MAC engine among NREQ requesters (e.g. per-layer neuron controllers).
- Sits between the requesters and the MAC bus, on the requester side of the MAC's module select, control word, finish flag and accumulated result.
- Per transaction, in order:
  - grants one requester;
  - drives the MAC select and that requester's control word, and issues a one-cycle start;
  - waits for the MAC finish flag, with a timeout;
  - returns the accumulated result to the owner.

---
 rtl/nn_mac_arbiter_if.sv | 50 +++++
 rtl/nn_mac_arbiter.sv | 156 +++++++++++++++
 tb/tb_nn_mac_arbiter.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/nn_mac_arbiter_if.sv
// -----------------------------------------------------------------------------
// nn_mac_arbiter_if
// Bundles the requester-side handshake and the MAC bus seen by the shared-MAC
// arbiter.
//   master : the arbiter. It drives grant/done/rsp_* and mac_sel/mac_ctrl/mac_start,
//            and it samples req/req_ctrl and mac_finish/mac_result.
//   slave  : the environment (requesters plus MAC engine), with the directions
//            reversed.
// Signals:
//   req        [NREQ]              request per requester, held until done
//   req_ctrl   [NREQ*(AWIDTH+1)]   control word per requester (slice i <-> req[i])
//   grant      [NREQ]              one-hot current owner
//   done       [NREQ]              one-cycle completion pulse to the owner
//   rsp_data   [D_LEN]             result returned to the owner
//   rsp_valid                      qualifies rsp_data, coincides with done
//   rsp_err                        transaction timed out
//   mac_sel                        MAC module select
//   mac_ctrl   [AWIDTH+1]          control word to the MAC
//   mac_start                      one-cycle start pulse
//   mac_finish                     MAC finish flag (level)
//   mac_result [D_LEN]             MAC accumulated result
// -----------------------------------------------------------------------------
interface nn_mac_arbiter_if #(
   parameter int NREQ   = 4,
   parameter int AWIDTH = 8,
   parameter int D_LEN  = 32
);
   logic [NREQ-1:0]            req;
   logic [NREQ*(AWIDTH+1)-1:0] req_ctrl;
   logic [NREQ-1:0]            grant;
   logic [NREQ-1:0]            done;
   logic [D_LEN-1:0]           rsp_data;
   logic                       rsp_valid;
   logic                       rsp_err;
   logic                       mac_sel;
   logic [AWIDTH:0]            mac_ctrl;
   logic                       mac_start;
   logic                       mac_finish;
   logic [D_LEN-1:0]           mac_result;

   modport master (
      input  req, req_ctrl, mac_finish, mac_result,
      output grant, done, rsp_data, rsp_valid, rsp_err, mac_sel, mac_ctrl, mac_start
   );

   modport slave (
      output req, req_ctrl, mac_finish, mac_result,
      input  grant, done, rsp_data, rsp_valid, rsp_err, mac_sel, mac_ctrl, mac_start
   );
endinterface

// File: rtl/nn_mac_arbiter.sv
// -----------------------------------------------------------------------------
// nn_mac_arbiter
// Round-robin arbiter and sequencer that shares one MAC engine among NREQ
// requesters. For each transaction it grants one requester, issues that
// requester's control word with a one-cycle start, and waits for the MAC
// finish flag, bounded by a timeout. It then returns the result with a done
// pulse.
// Ports:
//   clk          clock
//   rst_n        asynchronous active-low reset
//   bus          nn_mac_arbiter_if.master (requester handshake + MAC bus)
//   busy         high whenever the sequencer is not idle
//   timeout_cnt  saturating count of timed-out transactions
// -----------------------------------------------------------------------------
module nn_mac_arbiter #(
   parameter int NREQ    = 4,
   parameter int AWIDTH  = 8,
   parameter int D_LEN   = 32,
   parameter int TIMEOUT = 1023
) (
   input  logic              clk,
   input  logic              rst_n,
   nn_mac_arbiter_if.master  bus,
   output logic              busy,
   output logic [7:0]        timeout_cnt
);
   localparam int CW = AWIDTH + 1;
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int TW = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]       state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    owner;
   logic [TW-1:0]    wait_cnt;

   logic [NREQ-1:0]  grant_q;
   logic [NREQ-1:0]  done_q;
   logic [D_LEN-1:0] rsp_data_q;
   logic             rsp_valid_q;
   logic             rsp_err_q;
   logic             mac_sel_q;
   logic [CW-1:0]    mac_ctrl_q;
   logic             mac_start_q;

   logic             pick_vld;
   logic [IW-1:0]    pick_idx;

   function automatic logic [IW-1:0] wrap_idx(input int v);
      return IW'(v % NREQ);
   endfunction

   function automatic logic [NREQ-1:0] one_hot(input logic [IW-1:0] i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   // Scan downward so that the smallest offset from the pointer is written
   // last and therefore wins.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         if (bus.req[wrap_idx(int'(ptr) + i)]) begin
            pick_vld = 1'b1;
            pick_idx = wrap_idx(int'(ptr) + i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         owner       <= '0;
         wait_cnt    <= '0;
         grant_q     <= '0;
         done_q      <= '0;
         rsp_data_q  <= '0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         mac_sel_q   <= 1'b0;
         mac_ctrl_q  <= '0;
         mac_start_q <= 1'b0;
         timeout_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  owner       <= pick_idx;
                  mac_ctrl_q  <= bus.req_ctrl[pick_idx*CW +: CW];
                  grant_q     <= one_hot(pick_idx);
                  mac_sel_q   <= 1'b1;
                  mac_start_q <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               mac_start_q <= 1'b0;
               wait_cnt    <= '0;
               state       <= WAIT;
            end
            WAIT: begin
               wait_cnt <= wait_cnt + 1'b1;
               // wait_cnt == 0 marks the first WAIT cycle. A finish seen there
               // may still belong to the previous job, so it is ignored.
               if (wait_cnt != '0 && bus.mac_finish) begin
                  rsp_data_q  <= bus.mac_result;
                  rsp_err_q   <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  done_q      <= one_hot(owner);
                  state       <= DONE;
               end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                  rsp_data_q  <= '0;
                  rsp_err_q   <= 1'b1;
                  rsp_valid_q <= 1'b1;
                  done_q      <= one_hot(owner);
                  timeout_cnt <= sat_inc8(timeout_cnt);
                  state       <= DONE;
               end
            end
            DONE: begin
               done_q      <= '0;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               grant_q     <= '0;
               mac_sel_q   <= 1'b0;
               mac_ctrl_q  <= '0;
               ptr         <= wrap_idx(int'(owner) + 1);
               state       <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy          = (state != IDLE);
   assign bus.grant     = grant_q;
   assign bus.done      = done_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.mac_sel   = mac_sel_q;
   assign bus.mac_ctrl  = mac_ctrl_q;
   assign bus.mac_start = mac_start_q;
endmodule

// File: tb/tb_nn_mac_arbiter.sv
// -----------------------------------------------------------------------------
// tb_nn_mac_arbiter
// Directed and randomized bench for nn_mac_arbiter. A small reference model
// tracks the round-robin pointer and the timeout count. The expected owner,
// latency and response of each transaction are derived from that model.
// -----------------------------------------------------------------------------
module tb_nn_mac_arbiter;
   localparam int NREQ    = 4;
   localparam int AWIDTH  = 8;
   localparam int D_LEN   = 32;
   localparam int TIMEOUT = 1023;
   localparam int CW      = AWIDTH + 1;

   logic             clk       = 1'b0;
   logic             rst_n     = 1'b0;
   logic             busy;
   logic [7:0]       timeout_cnt;
   logic [NREQ-1:0]  tb_req    = '0;
   logic [NREQ*CW-1:0] tb_ctrl = '0;
   logic             tb_finish = 1'b0;
   logic [D_LEN-1:0] tb_result = '0;

   int checks = 0;
   int errors = 0;

   // reference model state
   int               m_ptr   = 0;
   int               m_tocnt = 0;
   logic [D_LEN-1:0] m_last  = '0;

   nn_mac_arbiter_if #(.NREQ(NREQ), .AWIDTH(AWIDTH), .D_LEN(D_LEN)) bus ();

   assign bus.req        = tb_req;
   assign bus.req_ctrl   = tb_ctrl;
   assign bus.mac_finish = tb_finish;
   assign bus.mac_result = tb_result;

   nn_mac_arbiter #(
      .NREQ(NREQ), .AWIDTH(AWIDTH), .D_LEN(D_LEN), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus),
      .busy(busy),
      .timeout_cnt(timeout_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // first requesting index at or above the pointer, wrapping around
   function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
      for (int i = 0; i < NREQ; i++) begin
         if (r[(p + i) % NREQ]) return (p + i) % NREQ;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] oh(input int i);
      logic [NREQ-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   // fin_k >= 0 : finish raised k negedges after the start is seen
   // fin_k == -1: finish already high before ISSUE (stale)
   // fin_k == -2: finish never raised (timeout)
   task automatic run_txn(input int fin_k, input logic [D_LEN-1:0] res,
                          input bit keep_req, input bit drop_test);
      int               owner;
      int               a;
      int               j;
      bit               got;
      bit               hold_ok;
      bit               exp_err;
      logic [CW-1:0]    ectrl;
      logic [D_LEN-1:0] edata;

      owner     = model_pick(tb_req, m_ptr);
      if (owner < 0) owner = 0;
      ectrl     = tb_ctrl[owner*CW +: CW];
      tb_result = res;
      if (fin_k == -1) tb_finish = 1'b1;

      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (bus.mac_start === 1'b1) got = 1;
      end
      chk("start_seen", 64'(got), 64'(1));
      if (!got) return;
      chk("issue_grant", 64'(bus.grant), 64'(oh(owner)));
      chk("issue_ctrl", 64'(bus.mac_ctrl), 64'(ectrl));
      chk("issue_sel", 64'(bus.mac_sel), 64'(1));
      chk("issue_busy", 64'(busy), 64'(1));
      if (fin_k == 0) tb_finish = 1'b1;

      if (fin_k == -2) a = TIMEOUT + 1;
      else if (fin_k < 0) a = 3;
      else a = (fin_k + 1 > 3) ? fin_k + 1 : 3;

      got = 0;
      hold_ok = 1;
      j = 0;
      while (!got && j < TIMEOUT + 20) begin
         tick();
         j++;
         if (bus.done !== '0) begin
            got = 1;
         end else begin
            if (bus.mac_start !== 1'b0 || bus.mac_sel !== 1'b1 ||
                bus.grant !== oh(owner) || bus.rsp_valid !== 1'b0) hold_ok = 0;
            if (drop_test && j == 1) begin
               tb_req[owner] = 1'b0;
               tb_ctrl[owner*CW +: CW] = ~ectrl;
            end
            if (fin_k > 0 && j == fin_k) tb_finish = 1'b1;
         end
      end
      chk("wait_hold", 64'(hold_ok), 64'(1));
      chk("done_seen", 64'(got), 64'(1));
      if (!got) return;

      exp_err = (fin_k == -2);
      edata   = exp_err ? '0 : res;
      if (exp_err) m_tocnt = (m_tocnt < 255) ? m_tocnt + 1 : 255;
      chk("done_latency", 64'(j), 64'(a));
      chk("done_vec", 64'(bus.done), 64'(oh(owner)));
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(1));
      chk("rsp_err", 64'(bus.rsp_err), 64'(exp_err));
      chk("rsp_data", 64'(bus.rsp_data), 64'(edata));
      chk("done_grant", 64'(bus.grant), 64'(oh(owner)));
      chk("done_sel", 64'(bus.mac_sel), 64'(1));
      chk("done_ctrl", 64'(bus.mac_ctrl), 64'(ectrl));
      chk("timeout_cnt", 64'(timeout_cnt), 64'(m_tocnt));

      m_last    = edata;
      m_ptr     = (owner + 1) % NREQ;
      tb_finish = 1'b0;
      if (!keep_req) tb_req[owner] = 1'b0;
      tb_ctrl[owner*CW +: CW] = CW'($urandom);

      tick();
      chk("idle_done", 64'(bus.done), 64'(0));
      chk("idle_valid", 64'(bus.rsp_valid), 64'(0));
      chk("idle_grant", 64'(bus.grant), 64'(0));
      chk("idle_sel", 64'(bus.mac_sel), 64'(0));
      chk("idle_ctrl", 64'(bus.mac_ctrl), 64'(0));
      chk("idle_busy", 64'(busy), 64'(0));
      chk("idle_data_hold", 64'(bus.rsp_data), 64'(m_last));
   endtask

   initial begin
      bit got;

      // reset state
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_grant", 64'(bus.grant), 64'(0));
      chk("rst_done", 64'(bus.done), 64'(0));
      chk("rst_data", 64'(bus.rsp_data), 64'(0));
      chk("rst_valid", 64'(bus.rsp_valid), 64'(0));
      chk("rst_err", 64'(bus.rsp_err), 64'(0));
      chk("rst_sel", 64'(bus.mac_sel), 64'(0));
      chk("rst_ctrl", 64'(bus.mac_ctrl), 64'(0));
      chk("rst_start", 64'(bus.mac_start), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_tocnt", 64'(timeout_cnt), 64'(0));
      rst_n = 1'b1;
      tick();

      // single requester, finish 6 cycles after start
      tb_ctrl[0*CW +: CW] = 9'h0A5;
      tb_req = 4'b0001;
      run_txn(6, 32'h0000_1234, 0, 0);

      // all four requesting continuously, MAC finishing every 3 cycles
      for (int i = 0; i < NREQ; i++) tb_ctrl[i*CW +: CW] = CW'($urandom);
      tb_req = 4'b1111;
      for (int t = 0; t < 8; t++) run_txn(2, D_LEN'($urandom), 1, 0);
      tb_req = '0;
      tick();

      // finish stuck high from before ISSUE
      tb_req = 4'b0010;
      run_txn(-1, D_LEN'($urandom), 0, 0);

      // requester 2 drops req and changes ctrl after ISSUE
      tb_req = 4'b0100;
      run_txn(3, D_LEN'($urandom), 0, 1);
      tick();
      tick();
      chk("drop_no_regrant", 64'(busy), 64'(0));
      chk("drop_no_done", 64'(bus.done), 64'(0));

      // timeout, then the other pending requester is served
      tb_req = 4'b1001;
      run_txn(-2, D_LEN'($urandom) | 32'h1, 0, 0);
      run_txn(1, D_LEN'($urandom), 0, 0);

      // randomized traffic
      for (int t = 0; t < 24; t++) begin
         if (tb_req == '0) tb_req = NREQ'($urandom_range(1, (1 << NREQ) - 1));
         run_txn(int'($urandom_range(0, 6)) - 1, D_LEN'($urandom),
                 bit'($urandom_range(0, 1)), 0);
      end
      tb_req = '0;
      tick();
      tick();

      // leave the pointer at 1, then reset in the middle of a WAIT
      tb_req = 4'b0001;
      run_txn(2, D_LEN'($urandom), 0, 0);
      tb_req = 4'b0100;
      got = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         tick();
         if (bus.mac_start === 1'b1) got = 1;
      end
      chk("rst_txn_start", 64'(got), 64'(1));
      tick();
      tick();
      rst_n = 1'b0;
      #1;
      chk("async_rst_grant", 64'(bus.grant), 64'(0));
      chk("async_rst_sel", 64'(bus.mac_sel), 64'(0));
      chk("async_rst_busy", 64'(busy), 64'(0));
      chk("async_rst_done", 64'(bus.done), 64'(0));
      chk("async_rst_start", 64'(bus.mac_start), 64'(0));
      chk("async_rst_tocnt", 64'(timeout_cnt), 64'(0));
      tb_req = 4'b1111;
      tick();
      tick();
      chk("held_rst_busy", 64'(busy), 64'(0));
      rst_n   = 1'b1;
      m_ptr   = 0;
      m_tocnt = 0;
      run_txn(2, D_LEN'($urandom), 0, 0);
      tb_req = '0;
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
